controller_fsm: RTL and testbench

//  Multi-cycle control unit; drives every control input of the 8-bit datapath and consumes its INSTR and accout.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/controller_fsm_if.sv | 29 ++
 rtl/controller_fsm_instr_decoder.sv | 41 ++++
 rtl/controller_fsm.sv | 97 +++++++++
 tb/tb_controller_fsm.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU controller and datapath:
// FSM states, instruction classes and datapath mux/op codes.
package cpu_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    CLS_LDR, CLS_STR, CLS_ALU, CLS_SHIFT, CLS_IN, CLS_OUT,
    CLS_NOP, CLS_HALT, CLS_LDM, CLS_JZ, CLS_JMP
  } cls_e;

  localparam logic [1:0] OP_REG = 2'b00;
  localparam logic [1:0] OP_LDM = 2'b01;
  localparam logic [1:0] OP_JZ  = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam logic [2:0] SUB_LDR  = 3'b000;
  localparam logic [2:0] SUB_STR  = 3'b001;
  localparam logic [2:0] SUB_MISC = 3'b111;

  localparam logic [1:0] ASEL_SHIFT = 2'd0;
  localparam logic [1:0] ASEL_RF    = 2'd1;
  localparam logic [1:0] ASEL_IN    = 2'd2;
  localparam logic [1:0] ASEL_MEM   = 2'd3;

  localparam logic [1:0] JMP_INC  = 2'd0;
  localparam logic [1:0] JMP_ABS  = 2'd1;
  localparam logic [1:0] JMP_BACK = 2'd2;
  localparam logic [1:0] JMP_FWD  = 2'd3;

  localparam logic [2:0] ALU_PASSA = 3'b000;

  localparam logic [1:0] SHIFT_PASS = 2'd0;
  localparam logic [1:0] SHIFT_SHL  = 2'd1;
  localparam logic [1:0] SHIFT_SHR  = 2'd2;
  localparam logic [1:0] SHIFT_ROR  = 2'd3;
endpackage

// File: rtl/controller_fsm_if.sv
// Controller <-> datapath signal bundle; master = controller side.
interface controller_fsm_if #(parameter int CNT_W = 16);
  logic [7:0]       INSTR;
  logic [7:0]       accout;
  logic             IRload;
  logic             MRload;
  logic             PCload;
  logic [1:0]       Jmpmuxsel;
  logic             MemInst;
  logic [1:0]       Asel;
  logic             Aload;
  logic             RFwr;
  logic [2:0]       ALUsel;
  logic [1:0]       Shiftsel;
  logic             outen;
  logic             halted;
  logic [CNT_W-1:0] instret;

  modport master (
    input  INSTR, accout,
    output IRload, MRload, PCload, Jmpmuxsel, MemInst, Asel, Aload,
           RFwr, ALUsel, Shiftsel, outen, halted, instret
  );
  modport slave (
    output INSTR, accout,
    input  IRload, MRload, PCload, Jmpmuxsel, MemInst, Asel, Aload,
           RFwr, ALUsel, Shiftsel, outen, halted, instret
  );
endinterface

// File: rtl/controller_fsm_instr_decoder.sv
// Combinational instruction classifier plus field extraction.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] instr,
  output cls_e       cls,
  output logic [2:0] alu_op,
  output logic [1:0] shift_op,
  output logic       jz_back
);
  assign alu_op   = instr[5:3];
  assign shift_op = instr[1:0];
  assign jz_back  = instr[5];

  always_comb begin
    cls = CLS_NOP;
    case (instr[7:6])
      OP_LDM: cls = CLS_LDM;
      OP_JZ:  cls = CLS_JZ;
      OP_JMP: cls = CLS_JMP;
      default: begin
        case (instr[5:3])
          SUB_LDR:  cls = CLS_LDR;
          SUB_STR:  cls = CLS_STR;
          SUB_MISC: begin
            if (!instr[2]) cls = CLS_SHIFT;
            else begin
              case (instr[1:0])
                2'b00:   cls = CLS_IN;
                2'b01:   cls = CLS_OUT;
                2'b10:   cls = CLS_NOP;
                default: cls = CLS_HALT;
              endcase
            end
          end
          default:  cls = CLS_ALU;
        endcase
      end
    endcase
  end
endmodule

// File: rtl/controller_fsm.sv
// Fetch/decode/execute control unit: state register, instret counter and
// per-state control decode for the 8-bit datapath.
module controller_fsm
  import cpu_pkg::*;
#(parameter int CNT_W = 16)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  controller_fsm_if.master  bus
);
  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, dec_cls;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [2:0]       dec_alu;
  logic [1:0]       dec_shift;
  logic             dec_back;

  instr_decoder u_dec (
    .instr(bus.INSTR), .cls(dec_cls), .alu_op(dec_alu),
    .shift_op(dec_shift), .jz_back(dec_back)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cls_q     <= CLS_NOP;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    instret_d     = instret_q;
    bus.IRload    = 1'b0;
    bus.MRload    = 1'b0;
    bus.PCload    = 1'b0;
    bus.Jmpmuxsel = JMP_INC;
    bus.MemInst   = 1'b0;
    bus.Asel      = ASEL_SHIFT;
    bus.Aload     = 1'b0;
    bus.RFwr      = 1'b0;
    bus.ALUsel    = ALU_PASSA;
    bus.Shiftsel  = SHIFT_PASS;
    bus.outen     = 1'b0;
    bus.halted    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        // MA is loaded speculatively so LDM can use it in EXEC
        bus.IRload = 1'b1;
        bus.MRload = 1'b1;
        bus.PCload = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        cls_d   = dec_cls;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        instret_d = instret_q + 1'b1;
        state_d   = (cls_q == CLS_HALT) ? S_HALT : S_FETCH;
        case (cls_q)
          CLS_LDR: begin bus.Asel = ASEL_RF; bus.Aload = 1'b1; end
          CLS_STR: bus.RFwr = 1'b1;
          CLS_ALU: begin bus.ALUsel = dec_alu; bus.Aload = 1'b1; end
          CLS_SHIFT: begin bus.Shiftsel = dec_shift; bus.Aload = 1'b1; end
          CLS_IN:  begin bus.Asel = ASEL_IN; bus.Aload = 1'b1; end
          CLS_OUT: bus.outen = 1'b1;
          CLS_LDM: begin
            bus.MemInst = 1'b1;
            bus.Asel    = ASEL_MEM;
            bus.Aload   = 1'b1;
          end
          CLS_JZ: begin
            bus.Jmpmuxsel = dec_back ? JMP_BACK : JMP_FWD;
            bus.PCload    = (bus.accout == 8'h00);
          end
          CLS_JMP: begin
            bus.Jmpmuxsel = JMP_ABS;
            bus.PCload    = 1'b1;
          end
          default: ;
        endcase
      end
      S_HALT: bus.halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.instret = instret_q;
endmodule

// File: tb/tb_controller_fsm.sv
// Directed bench for controller_fsm: one 16-bit-counter DUT for the
// instruction sequences and one 4-bit-counter DUT for the wrap check.
module tb_controller_fsm;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, start_a, rst_b, start_b;
  int   n_run  = 0;
  int   n_fail = 0;

  controller_fsm_if #(.CNT_W(16)) bus_a ();
  controller_fsm_if #(.CNT_W(4))  bus_b ();

  controller_fsm #(.CNT_W(16)) dut_a (.clk(clk), .reset(rst_a), .start(start_a), .bus(bus_a));
  controller_fsm #(.CNT_W(4))  dut_b (.clk(clk), .reset(rst_b), .start(start_b), .bus(bus_b));

  // {IRload,MRload,PCload,Jmpmuxsel,MemInst,Asel,Aload,RFwr,ALUsel,Shiftsel,outen,halted}
  function automatic logic [16:0] ctl(logic ir, logic mr, logic pc, logic [1:0] jm,
                                      logic mi, logic [1:0] as, logic al, logic rf,
                                      logic [2:0] alu, logic [1:0] sh, logic oe, logic h);
    return {ir, mr, pc, jm, mi, as, al, rf, alu, sh, oe, h};
  endfunction

  function automatic logic [16:0] obs_a();
    return {bus_a.IRload, bus_a.MRload, bus_a.PCload, bus_a.Jmpmuxsel, bus_a.MemInst,
            bus_a.Asel, bus_a.Aload, bus_a.RFwr, bus_a.ALUsel, bus_a.Shiftsel,
            bus_a.outen, bus_a.halted};
  endfunction

  function automatic logic [16:0] obs_b();
    return {bus_b.IRload, bus_b.MRload, bus_b.PCload, bus_b.Jmpmuxsel, bus_b.MemInst,
            bus_b.Asel, bus_b.Aload, bus_b.RFwr, bus_b.ALUsel, bus_b.Shiftsel,
            bus_b.outen, bus_b.halted};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [16:0] ZERO  = 17'h0;
  localparam logic [16:0] FETCH = 17'h1C000;

  // Drive INSTR during FETCH, then walk DECODE into EXEC.
  task automatic to_exec_a(logic [7:0] ins);
    bus_a.INSTR = ins;
    step();
    chk("decode_zero", 32'(obs_a()), 32'(ZERO));
    step();
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b0; rst_b = 1'b1; start_b = 1'b0;
    bus_a.INSTR = 8'h00; bus_a.accout = 8'h00;
    bus_b.INSTR = 8'h3E; bus_b.accout = 8'h00;
    step(); step();
    chk("reset_ctl", 32'(obs_a()), 32'(ZERO));
    chk("reset_instret", 32'(bus_a.instret), 32'd0);

    rst_a = 1'b0;
    step();
    chk("idle_hold", 32'(obs_a()), 32'(ZERO));
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("fetch_ctl", 32'(obs_a()), 32'(FETCH));

    // ADD R1
    to_exec_a(8'h11);
    chk("add_exec", 32'(obs_a()), 32'(ctl(0,0,0,0,0,0,1,0,3'b010,0,0,0)));
    chk("add_instret0", 32'(bus_a.instret), 32'd0);
    step();
    chk("add_instret1", 32'(bus_a.instret), 32'd1);
    chk("fetch2_ctl", 32'(obs_a()), 32'(FETCH));

    // JZ forward, taken then not taken
    bus_a.accout = 8'h00;
    to_exec_a(8'h85);
    chk("jz_fwd_taken", 32'(obs_a()), 32'(ctl(0,0,1,3,0,0,0,0,0,0,0,0)));
    bus_a.accout = 8'h01;
    #1;
    chk("jz_fwd_not", 32'(obs_a()), 32'(ctl(0,0,0,3,0,0,0,0,0,0,0,0)));
    step();
    // JZ backward, taken
    bus_a.accout = 8'h00;
    to_exec_a(8'hA3);
    chk("jz_back_taken", 32'(obs_a()), 32'(ctl(0,0,1,2,0,0,0,0,0,0,0,0)));
    step();
    // LDM
    to_exec_a(8'h4A);
    chk("ldm_exec", 32'(obs_a()), 32'(ctl(0,0,0,0,1,3,1,0,0,0,0,0)));
    step();
    // JMP
    to_exec_a(8'hC0);
    chk("jmp_exec", 32'(obs_a()), 32'(ctl(0,0,1,1,0,0,0,0,0,0,0,0)));
    step();
    // STR R5
    to_exec_a(8'h0D);
    chk("str_exec", 32'(obs_a()), 32'(ctl(0,0,0,0,0,0,0,1,0,0,0,0)));
    step();
    // SHIFT ROR
    to_exec_a(8'h3B);
    chk("shift_exec", 32'(obs_a()), 32'(ctl(0,0,0,0,0,0,1,0,0,3,0,0)));
    step();
    chk("instret7", 32'(bus_a.instret), 32'd7);

    // HALT: retires, then sticks
    to_exec_a(8'h3F);
    chk("halt_exec", 32'(obs_a()), 32'(ZERO));
    step();
    chk("halted", 32'(obs_a()), 32'(ctl(0,0,0,0,0,0,0,0,0,0,0,1)));
    chk("halt_instret", 32'(bus_a.instret), 32'd8);
    start_a = 1'b1;
    step(); step();
    start_a = 1'b0;
    step();
    chk("halt_sticky", 32'(obs_a()), 32'(ctl(0,0,0,0,0,0,0,0,0,0,0,1)));
    rst_a = 1'b1;
    #1;
    chk("halt_reset_ctl", 32'(obs_a()), 32'(ZERO));
    chk("halt_reset_instret", 32'(bus_a.instret), 32'd0);

    // Reset mid-EXEC
    step();
    rst_a = 1'b0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    to_exec_a(8'h11);
    chk("pre_reset_exec", 32'(obs_a()), 32'(ctl(0,0,0,0,0,0,1,0,3'b010,0,0,0)));
    #2;
    rst_a = 1'b1;
    #1;
    chk("mid_reset_ctl", 32'(obs_a()), 32'(ZERO));
    chk("mid_reset_instret", 32'(bus_a.instret), 32'd0);
    step();
    rst_a = 1'b0;
    step();
    chk("post_reset_idle", 32'(obs_a()), 32'(ZERO));
    chk("post_reset_instret", 32'(bus_a.instret), 32'd0);

    // 4-bit counter wrap over 16 NOPs
    rst_b = 1'b0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("b_fetch", 32'(obs_b()), 32'(FETCH));
    for (int i = 1; i <= 16; i++) begin
      step(); step();
      chk("b_nop_exec", 32'(obs_b()), 32'(ZERO));
      step();
      chk($sformatf("b_instret_%0d", i), 32'(bus_b.instret), 32'(i % 16));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
